// File: rtl/switch_cell_pkg.sv
// Shared constants and helpers for the CGRA switch cells.
// The select field width is derived from the input count so a zero/disconnect code fits.
package switch_cell_pkg;

    localparam int SEL_DISCONNECT = 0;

    function automatic int sel_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/config_shadow_chain.sv
// Serial config shadow register with atomic commit into the active register.
// The shadow keeps shifting independently so live routing only ever sees committed values.
module config_shadow_chain #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_in,
    input  logic         shift_en,
    input  logic         commit,
    output logic [W-1:0] active,
    output logic         shift_out
);

    logic [W-1:0] shadow_d, shadow_q;
    logic [W-1:0] active_d, active_q;

    always_comb begin
        shadow_d = shadow_q;
        if (shift_en) begin
            shadow_d = {shadow_q[W-2:0], shift_in};
        end
    end

    // Commit takes the pre-shift shadow, even when a shift happens on the same edge.
    always_comb begin
        active_d = active_q;
        if (commit) begin
            active_d = shadow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign active    = active_q;
    assign shift_out = shadow_q[W-1];

endmodule

// File: rtl/fullyconn_nxm_reg.sv
// N-input, M-output fully connected switch cell with optional per-output pipeline register.
// Each output field in the active config holds {reg_mode, sel}; sel 0 or > N gives zero.
module fullyconn_nxm_reg
    import switch_cell_pkg::*;
#(
    parameter int N    = 6,
    parameter int M    = 1,
    parameter int size = 32
) (
    input  logic                config_clk,
    input  logic                config_reset,
    input  logic                config_in,
    input  logic                config_en,
    input  logic                config_commit,
    output logic                config_out,
    input  logic                data_en,
    input  logic [N*size-1:0]   in,
    output logic [M*size-1:0]   out
);

    localparam int SEL_W = sel_width(N);
    localparam int F     = SEL_W + 1;
    localparam int CFG_W = M * F;

    logic [CFG_W-1:0] active;

    config_shadow_chain #(
        .W (CFG_W)
    ) u_chain (
        .clk       (config_clk),
        .rst       (config_reset),
        .shift_in  (config_in),
        .shift_en  (config_en),
        .commit    (config_commit),
        .active    (active),
        .shift_out (config_out)
    );

    for (genvar j = 0; j < M; j++) begin : g_out
        logic [SEL_W-1:0] sel;
        logic             reg_mode;
        logic [size-1:0]  mux;
        logic [size-1:0]  pipe_d, pipe_q;

        assign sel      = active[j*F +: SEL_W];
        assign reg_mode = active[j*F + SEL_W];

        // Codes above the disconnect value map onto inputs; anything unmatched stays zero.
        always_comb begin
            mux = '0;
            for (int k = 0; k < N; k++) begin
                if (sel == SEL_W'(SEL_DISCONNECT + 1 + k)) begin
                    mux = in[k*size +: size];
                end
            end
        end

        always_comb begin
            pipe_d = pipe_q;
            if (data_en) begin
                pipe_d = mux;
            end
        end

        always_ff @(posedge config_clk) begin
            if (config_reset) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign out[j*size +: size] = reg_mode ? pipe_q : mux;
    end

endmodule

// File: tb/tb_fullyconn_nxm_reg.sv
// Directed bench for fullyconn_nxm_reg with N=6, M=2, size=32 (CFG_W=8).
module tb_fullyconn_nxm_reg;

    localparam int N    = 6;
    localparam int M    = 2;
    localparam int SZ   = 32;

    logic             config_clk = 1'b0;
    logic             config_reset;
    logic             config_in;
    logic             config_en;
    logic             config_commit;
    logic             config_out;
    logic             data_en;
    logic [N*SZ-1:0]  in_bus;
    logic [M*SZ-1:0]  out_bus;

    int n_checks = 0;
    int n_errors = 0;

    always #5 config_clk = ~config_clk;

    fullyconn_nxm_reg #(
        .N    (N),
        .M    (M),
        .size (SZ)
    ) dut (
        .config_clk    (config_clk),
        .config_reset  (config_reset),
        .config_in     (config_in),
        .config_en     (config_en),
        .config_commit (config_commit),
        .config_out    (config_out),
        .data_en       (data_en),
        .in            (in_bus),
        .out           (out_bus)
    );

    typedef struct {
        logic [7:0]  cfg;
        logic [31:0] e0_a, e1_a;
        logic [31:0] e0_mid, e1_mid;
        logic [31:0] e0_b, e1_b;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge config_clk);
        #1;
    endtask

    task automatic set_inputs(input logic [31:0] base);
        for (int k = 0; k < N; k++) in_bus[k*SZ +: SZ] = base + 32'(k);
    endtask

    task automatic shift_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            config_en = 1'b1;
            config_in = b[i];
            step();
        end
        config_en = 1'b0;
        config_in = 1'b0;
    endtask

    task automatic commit_pulse();
        config_commit = 1'b1;
        step();
        config_commit = 1'b0;
    endtask

    task automatic do_reset();
        config_reset = 1'b1;
        step();
        config_reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{8'hA6, 32'h1000_0005, 32'h1000_0001, 32'h2000_0005, 32'h1000_0001, 32'h2000_0005, 32'h2000_0001};
        vecs[1] = '{8'h07, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[2] = '{8'h19, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h2000_0000, 32'h2000_0000, 32'h2000_0000};
        vecs[3] = '{8'h0E, 32'h1000_0005, 32'h0, 32'h1000_0005, 32'h0, 32'h2000_0005, 32'h0};
        vecs[4] = '{8'h5B, 32'h1000_0002, 32'h1000_0004, 32'h1000_0002, 32'h2000_0004, 32'h2000_0002, 32'h2000_0004};
        vecs[5] = '{8'hF8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[6] = '{8'h3C, 32'h1000_0003, 32'h1000_0002, 32'h1000_0003, 32'h2000_0002, 32'h2000_0003, 32'h2000_0002};

        config_reset  = 1'b0;
        config_in     = 1'b0;
        config_en     = 1'b0;
        config_commit = 1'b0;
        data_en       = 1'b1;
        for (int k = 0; k < N; k++) in_bus[k*SZ +: SZ] = $urandom;
        #2;

        // Reset with random inputs
        do_reset();
        check("reset_out0", out_bus[0 +: SZ], 32'h0);
        check("reset_out1", out_bus[SZ +: SZ], 32'h0);
        check("reset_cfg_out", {31'h0, config_out}, 32'h0);

        // Program A6, nothing routes before commit
        set_inputs(32'h1000_0000);
        shift_byte(8'hA6);
        check("precommit_out0", out_bus[0 +: SZ], 32'h0);
        check("precommit_out1", out_bus[SZ +: SZ], 32'h0);
        commit_pulse();
        check("commit_out0_comb", out_bus[0 +: SZ], 32'h1000_0005);
        check("commit_out1_oldpipe", out_bus[SZ +: SZ], 32'h0);
        step();
        check("commit_out1_reg", out_bus[SZ +: SZ], 32'h1000_0001);

        // Table-driven configurations
        for (int v = 0; v < 7; v++) begin
            set_inputs(32'h1000_0000);
            shift_byte(vecs[v].cfg);
            commit_pulse();
            step();
            step();
            check($sformatf("v%0d_out0_a", v), out_bus[0 +: SZ], vecs[v].e0_a);
            check($sformatf("v%0d_out1_a", v), out_bus[SZ +: SZ], vecs[v].e1_a);
            set_inputs(32'h2000_0000);
            #1;
            check($sformatf("v%0d_out0_mid", v), out_bus[0 +: SZ], vecs[v].e0_mid);
            check($sformatf("v%0d_out1_mid", v), out_bus[SZ +: SZ], vecs[v].e1_mid);
            step();
            check($sformatf("v%0d_out0_b", v), out_bus[0 +: SZ], vecs[v].e0_b);
            check($sformatf("v%0d_out1_b", v), out_bus[SZ +: SZ], vecs[v].e1_b);
        end

        // Chain passthrough
        do_reset();
        shift_byte(8'hA6);
        begin
            logic [7:0] exp_bits;
            exp_bits = 8'hA6;
            for (int i = 0; i < 8; i++) begin
                check($sformatf("chain_bit%0d", i), {31'h0, config_out}, {31'h0, exp_bits[7-i]});
                config_en = 1'b1;
                config_in = 1'b0;
                step();
            end
            config_en = 1'b0;
        end
        check("chain_drained", {31'h0, config_out}, 32'h0);

        // Simultaneous shift and commit
        set_inputs(32'h1000_0000);
        shift_byte(8'hA6);
        config_en     = 1'b1;
        config_in     = 1'b1;
        config_commit = 1'b1;
        step();
        config_en     = 1'b0;
        config_in     = 1'b0;
        config_commit = 1'b0;
        check("sim_active", {24'h0, dut.u_chain.active_q}, 32'h0000_00A6);
        check("sim_shadow", {24'h0, dut.u_chain.shadow_q}, 32'h0000_004D);
        check("sim_out0", out_bus[0 +: SZ], 32'h1000_0005);
        check("sim_cfg_out", {31'h0, config_out}, 32'h0);

        // Hold with data_en low, then mid-operation reset
        step();
        check("hold_start_out1", out_bus[SZ +: SZ], 32'h1000_0001);
        data_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_inputs(32'h3000_0000 + 32'(c * 16));
            step();
            check($sformatf("hold%0d_out1", c), out_bus[SZ +: SZ], 32'h1000_0001);
            check($sformatf("hold%0d_out0", c), out_bus[0 +: SZ], 32'h3000_0005 + 32'(c * 16));
        end
        data_en = 1'b1;
        do_reset();
        check("rst2_out0", out_bus[0 +: SZ], 32'h0);
        check("rst2_out1", out_bus[SZ +: SZ], 32'h0);
        check("rst2_cfg_out", {31'h0, config_out}, 32'h0);
        set_inputs(32'h1000_0000);
        step();
        step();
        check("post_rst_out0", out_bus[0 +: SZ], 32'h0);
        check("post_rst_out1", out_bus[SZ +: SZ], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fullyconn_nxm_reg.md
# fullyconn_nxm_reg

Parametrised N-input, M-output fully connected switch cell for the CGRA interconnect. It is the generalised successor of the fixed 6-to-1 switch cell. Each output independently selects any input or a constant zero. Each output can optionally be registered, so that routing paths can be pipelined. Configuration arrives on the serial config chain into a shadow register and becomes active atomically on a commit pulse, so live routing never sees a half-shifted configuration.

## Interface
- `N`, default 6: number of data inputs (≥2).
- `M`, default 1: number of data outputs (≥1).
- `size`, default 32: data width per port.
- Derived constants:
  - `SEL_W = $clog2(N+1)`: select field width.
  - `F = SEL_W+1`: bits per output field.
  - `CFG_W = M*F`: total config chain length.
- Ports:
  - `config_clk`: in, 1. Single clock for the config chain and the data pipeline registers.
  - `config_reset`: in, 1. Reset, synchronous, active-high.
  - `config_in`: in, 1. Serial config bit from the upstream cell.
  - `config_en`: in, 1. Shift enable for the shadow chain.
  - `config_commit`: in, 1. Single-cycle pulse; copies shadow to active.
  - `config_out`: out, 1. Serial config bit to the downstream cell; equals shadow[CFG_W-1].
  - `data_en`: in, 1. Load enable for the output pipeline registers.
  - `in`: in, N*size. Packed inputs; input k is `in[k*size +: size]`.
  - `out`: out, M*size. Packed outputs; output j is `out[j*size +: size]`.

## Operation
- Field layout: output j owns `active[j*F +: F]`.
  - bits [SEL_W-1:0]: `sel`.
  - bit SEL_W: `reg_mode`.
- Select decode:
  - `sel` = 0 gives zero (disconnected).
  - `sel` = k, for 1 ≤ k ≤ N, gives input k-1.
  - `sel` > N gives zero.
- Data path per output:
  - `mux_j` = decode of the active select.
  - Pipeline register `pipe_j` loads `mux_j` on every edge where `data_en`=1, whatever the value of `reg_mode`. When `data_en`=0 it holds.
  - `out_j` = `reg_mode` ? `pipe_j` : `mux_j`.
- Config shift: on an edge with `config_en`=1, shadow <= {shadow[CFG_W-2:0], config_in}.
  - The stream is therefore MSB-first: the first bit shifted in lands at shadow[CFG_W-1] after CFG_W shifts.
- Commit: on an edge with `config_commit`=1, active <= shadow value present before that edge.
  - With `config_en`=1 in the same cycle, the shift still happens and the pre-shift shadow is committed.
- Reset (synchronous) clears shadow, active and every `pipe_j` to 0.
  - All outputs therefore read 0 and `config_out` reads 0 from the cycle after the reset edge.
  - Reset overrides shift, commit and `data_en` in the same cycle.
  - A reset in the middle of shifting discards the partial configuration.

## Timing
- Combinational mode: `in` to `out` with 0 cycles of latency.
- Registered mode: 1 cycle of latency (with `data_en`=1).
- A commit at edge t means the new select and mode drive `out` from just after t.
  - A registered output shows the newly selected input's data from edge t+1.
  - Between t and t+1 it shows `pipe_j`, which was loaded at t through the old select.
- Switching an output from combinational to registered mode exposes the last `pipe_j` value immediately; there is no bubble insertion.
- Chain delay: `config_out` is a registered bit, giving CFG_W shift cycles from `config_in` to `config_out`.
- `config_commit` held high for several cycles re-commits the shadow each cycle. This is legal; the block does not detect it.

## Structure
- Package `switch_cell_pkg`:
  - Function `sel_width(n)` returning `$clog2(n+1)`.
  - Constant `SEL_DISCONNECT = 0`.
- Sub-module `config_shadow_chain` (parameter `W`), containing:
  - The shift register.
  - The active register.
  - The commit logic.
  - The tap for `config_out`.
- The top level holds M mux instances and M pipeline registers, built with a generate loop.

## Test plan
All scenarios use N=6, M=2, size=32, so SEL_W=3, F=4, CFG_W=8. Inputs are `in k` = 32'h1000_0000+k.

- Reset: assert `config_reset` for 1 cycle with random inputs → `out`=0 and `config_out`=0 on the following cycle.
- Program and commit:
  - Shift 8'hA6 MSB-first, i.e. out1 = reg/sel2 and out0 = comb/sel6, and check `out` is still 0 before commit.
  - Pulse `config_commit`.
  - Required: out0 = 32'h1000_0005 with the same cycle as `in`, and out1 = 32'h1000_0001 one cycle after `in`.
- Out-of-range select: commit out0 field = 4'b0111 (sel 7) → out0 = 0.
- Chain passthrough: shift 8'hA6 followed by 8 zeros → `config_out` emits 1,0,1,0,0,1,1,0 on shifts 9–16.
- Simultaneous shift and commit:
  - With shadow = 8'hA6, raise `config_en` (`config_in`=1) and `config_commit` together.
  - Required: active = 8'hA6 and shadow = 8'h4D.
- Hold and mid-operation reset:
  - In registered mode, drop `data_en` for 3 cycles while changing `in` → out1 holds its value.
  - Then assert `config_reset` → all outputs are 0 on the next cycle, and a new commit is required before traffic routes again.
